// File: rtl/binarynet_mem_pkg.sv
// Shared definitions for the binarynet on-chip buffer: collision modes,
// lane count derivation and the clear-sweep state encoding.
package binarynet_mem_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_READY = 1'b1
  } clr_state_t;

  function automatic int lanes_of(input int dw, input int bw);
    return dw / bw;
  endfunction

endpackage

// File: rtl/dp_sram_rdpipe.sv
// Read-data/valid pipeline for one SRAM port; RD_LAT=2 adds an output stage.
// Data registers only load on a valid beat so rdata holds between reads.
module dp_sram_rdpipe #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  logic          r_vld1;
  logic [DW-1:0] r_data1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1  <= 1'b0;
      r_data1 <= '0;
    end else begin
      r_vld1 <= i_vld;
      if (i_vld) r_data1 <= i_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          r_vld2;
      logic [DW-1:0] r_data2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld2  <= 1'b0;
          r_data2 <= '0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_data2 <= r_data1;
        end
      end

      assign o_vld  = r_vld2;
      assign o_data = r_data2;
    end else begin : g_lat1
      assign o_vld  = r_vld1;
      assign o_data = r_data1;
    end
  endgenerate

endmodule

// File: rtl/dp_sram_be.sv
// True dual-port SRAM with per-lane write enables, defined same-address
// collision behaviour and an optional zeroing sweep after reset release.
module dp_sram_be
  import binarynet_mem_pkg::*;
#(
  parameter int  DW         = 32,
  parameter int  AW         = 6,
  parameter int  BW         = 8,
  parameter int  RD_LAT     = 1,
  parameter int  WR_MODE    = RD_FIRST,
  parameter int  CLR_ON_RST = 1,
  localparam int NL         = lanes_of(DW, BW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [NL-1:0] a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [NL-1:0] b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          busy,
  output logic          collision
);

  localparam int DP = 1 << AW;

  logic [DW-1:0] r_mem [DP];
  logic          r_collision;
  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_a_rd, w_b_rd, w_same;
  logic [NL-1:0] w_a_be_eff, w_b_be_eff;
  logic [DW-1:0] w_a_old, w_b_old, w_a_word, w_b_word;

  assign w_a_rd     = a_en & ~a_we & ~w_busy;
  assign w_b_rd     = b_en & ~b_we & ~w_busy;
  assign w_a_be_eff = (a_en & a_we & ~w_busy) ? a_be : '0;
  assign w_b_be_eff = (b_en & b_we & ~w_busy) ? b_be : '0;
  assign w_same     = (a_addr == b_addr);

  // B is applied first so that A owns any lane both ports write.
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    for (int li = 0; li < NL; li++) begin
      if (w_b_be_eff[li]) r_mem[b_addr][li*BW +: BW] <= b_wdata[li*BW +: BW];
      if (w_a_be_eff[li]) r_mem[a_addr][li*BW +: BW] <= a_wdata[li*BW +: BW];
    end
  end

  assign w_a_old = r_mem[a_addr];
  assign w_b_old = r_mem[b_addr];

  // Write-first mode forwards the other port's written lanes into the read.
  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_fwd
      assign w_a_word[gi*BW +: BW] = (WR_MODE == WR_FIRST && w_same && w_b_be_eff[gi])
                                     ? b_wdata[gi*BW +: BW] : w_a_old[gi*BW +: BW];
      assign w_b_word[gi*BW +: BW] = (WR_MODE == WR_FIRST && w_same && w_a_be_eff[gi])
                                     ? a_wdata[gi*BW +: BW] : w_b_old[gi*BW +: BW];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_collision <= 1'b0;
    else        r_collision <= w_same & (|(w_a_be_eff & w_b_be_eff));
  end

  generate
    if (CLR_ON_RST != 0) begin : g_clr
      clr_state_t    r_state, w_state_next;
      logic [AW-1:0] r_cnt, w_cnt_next;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= CLR_CLEAR;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
          CLR_CLEAR: begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == AW'(DP - 1)) w_state_next = CLR_READY;
          end
          default: ;
        endcase
      end

      assign w_busy     = (r_state == CLR_CLEAR);
      assign w_clr_we   = w_busy;
      assign w_clr_addr = r_cnt;
    end else begin : g_noclr
      assign w_busy     = 1'b0;
      assign w_clr_we   = 1'b0;
      assign w_clr_addr = '0;
    end
  endgenerate

  dp_sram_rdpipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_a_rd),
    .i_data (w_a_word),
    .o_vld  (a_rvalid),
    .o_data (a_rdata)
  );

  dp_sram_rdpipe #(.DW(DW), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_b_rd),
    .i_data (w_b_word),
    .o_vld  (b_rvalid),
    .o_data (b_rdata)
  );

  assign busy      = w_busy;
  assign collision = r_collision;

endmodule

// File: tb/tb_dp_sram_be.sv
// Bench for dp_sram_be: one read-first/RD_LAT=1 instance and one
// write-first/RD_LAT=2 instance driven in parallel against an array model.
module tb_dp_sram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, a_addr, b_be, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
  logic        busy0, busy1, col0, col1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dp_sram_be #(.DW(32), .AW(4), .BW(8), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
    .busy(busy0), .collision(col0)
  );

  dp_sram_be #(.DW(32), .AW(4), .BW(8), .RD_LAT(2), .WR_MODE(1), .CLR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
    .busy(busy1), .collision(col1)
  );

  // Reference model state
  logic [31:0] mem_m [16];
  int          bcnt;
  logic [31:0] hold0_a, hold0_b, hold1_a, hold1_b;
  logic        pend1_a_v, pend1_b_v;
  logic [31:0] pend1_a_d, pend1_b_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic set_idle();
    a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
  endtask

  // One clock: predict from current inputs, step the edge, compare everything.
  task automatic cycle();
    bit          bsy, awr, ard, bwr, brd, same, col_e;
    bit          e0av, e0bv, e1av, e1bv;
    logic [31:0] a_old, b_old, a_new, b_new;
    bsy   = (bcnt > 0);
    awr   = a_en && a_we && !bsy;
    ard   = a_en && !a_we && !bsy;
    bwr   = b_en && b_we && !bsy;
    brd   = b_en && !b_we && !bsy;
    same  = (a_addr == b_addr);
    col_e = awr && bwr && same && ((a_be & b_be) != 4'h0);
    a_old = mem_m[a_addr];
    b_old = mem_m[b_addr];
    a_new = (ard && bwr && same) ? merge(a_old, b_wdata, b_be) : a_old;
    b_new = (brd && awr && same) ? merge(b_old, a_wdata, a_be) : b_old;
    @(posedge clk);
    if (bwr) mem_m[b_addr] = merge(mem_m[b_addr], b_wdata, b_be);
    if (awr) mem_m[a_addr] = merge(mem_m[a_addr], a_wdata, a_be);
    if (bcnt > 0) bcnt--;
    e0av = ard; e0bv = brd;
    if (ard) hold0_a = a_old;
    if (brd) hold0_b = b_old;
    e1av = pend1_a_v; e1bv = pend1_b_v;
    if (pend1_a_v) hold1_a = pend1_a_d;
    if (pend1_b_v) hold1_b = pend1_b_d;
    pend1_a_v = ard; pend1_a_d = a_new;
    pend1_b_v = brd; pend1_b_d = b_new;
    #1;
    chk("m_busy0", 32'(busy0), 32'(bcnt > 0));
    chk("m_busy1", 32'(busy1), 32'(bcnt > 0));
    chk("m_col0", 32'(col0), 32'(col_e));
    chk("m_col1", 32'(col1), 32'(col_e));
    chk("m_a_rvalid0", 32'(a_rvalid0), 32'(e0av));
    chk("m_b_rvalid0", 32'(b_rvalid0), 32'(e0bv));
    chk("m_a_rdata0", a_rdata0, hold0_a);
    chk("m_b_rdata0", b_rdata0, hold0_b);
    chk("m_a_rvalid1", 32'(a_rvalid1), 32'(e1av));
    chk("m_b_rvalid1", 32'(b_rvalid1), 32'(e1bv));
    chk("m_a_rdata1", a_rdata1, hold1_a);
    chk("m_b_rdata1", b_rdata1, hold1_b);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    hold0_a = 0; hold0_b = 0; hold1_a = 0; hold1_b = 0;
    pend1_a_v = 0; pend1_b_v = 0; pend1_a_d = 0; pend1_b_d = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    chk("rst_a_rdata0", a_rdata0, 32'h0);
    chk("rst_a_rvalid0", 32'(a_rvalid0), 32'h0);
    chk("rst_b_rdata1", b_rdata1, 32'h0);
    chk("rst_a_rvalid1", 32'(a_rvalid1), 32'h0);
    chk("rst_col0", 32'(col0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h1);
    chk("rst_busy1", 32'(busy1), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    bcnt  = 16;
  endtask

  // Counts busy cycles after release while a read of addr 5 is held on port A.
  task automatic measure_busy(input string name);
    int nb;
    set_idle();
    a_en = 1; a_addr = 4'd5;
    nb = busy0 ? 1 : 0;
    for (int i = 0; i < 40 && busy0; i++) begin
      cycle();
      if (busy0) nb++;
    end
    chk(name, 32'(nb), 32'd16);
  endtask

  typedef struct {
    logic        a_en, a_we;
    logic [3:0]  a_be, a_addr;
    logic [31:0] a_wd;
    logic        b_en, b_we;
    logic [3:0]  b_be, b_addr;
    logic [31:0] b_wd;
    logic        col;
    logic        a_rv0; logic [31:0] a_rd0;
    logic        b_rv0; logic [31:0] b_rd0;
    logic        a_rv1; logic [31:0] a_rd1;
    logic        b_rv1; logic [31:0] b_rd1;
  } vec_t;

  vec_t vt [15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // a_en we be addr wdata | b_en we be addr wdata | col | d0 a | d0 b | d1 a | d1 b
    vt[0]  = '{1'b1,1'b1,4'hF,4'd3,32'hAABBCCDD, 1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0};
    vt[1]  = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b1,1'b1,4'h5,4'd3,32'h11223344, 1'b0, 1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0};
    vt[2]  = '{1'b1,1'b0,4'h0,4'd3,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b1,32'hAA22CC44, 1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0};
    vt[3]  = '{1'b1,1'b1,4'h1,4'd7,32'h000000FF, 1'b1,1'b1,4'hD,4'd7,32'hFFFF00EE, 1'b1, 1'b0,32'hAA22CC44, 1'b0,32'h0,        1'b1,32'hAA22CC44, 1'b0,32'h0};
    vt[4]  = '{1'b1,1'b0,4'h0,4'd7,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b1,32'hFFFF00FF, 1'b0,32'h0,        1'b0,32'hAA22CC44, 1'b0,32'h0};
    vt[5]  = '{1'b1,1'b1,4'h1,4'd7,32'h000000FF, 1'b1,1'b1,4'hC,4'd7,32'hFFFF00EE, 1'b0, 1'b0,32'hFFFF00FF, 1'b0,32'h0,        1'b1,32'hFFFF00FF, 1'b0,32'h0};
    vt[6]  = '{1'b1,1'b1,4'hF,4'd2,32'h12345678, 1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b0,32'hFFFF00FF, 1'b0,32'h0,        1'b0,32'hFFFF00FF, 1'b0,32'h0};
    vt[7]  = '{1'b1,1'b1,4'hF,4'd2,32'hDEADBEEF, 1'b1,1'b0,4'h0,4'd2,32'h0,        1'b0, 1'b0,32'hFFFF00FF, 1'b1,32'h12345678, 1'b0,32'hFFFF00FF, 1'b0,32'h0};
    vt[8]  = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b1,1'b1,4'hF,4'd0,32'h01010101, 1'b0, 1'b0,32'hFFFF00FF, 1'b0,32'h12345678, 1'b0,32'hFFFF00FF, 1'b1,32'hDEADBEEF};
    vt[9]  = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b1,1'b1,4'hF,4'd1,32'h02020202, 1'b0, 1'b0,32'hFFFF00FF, 1'b0,32'h12345678, 1'b0,32'hFFFF00FF, 1'b0,32'hDEADBEEF};
    vt[10] = '{1'b1,1'b0,4'h0,4'd0,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b1,32'h01010101, 1'b0,32'h12345678, 1'b0,32'hFFFF00FF, 1'b0,32'hDEADBEEF};
    vt[11] = '{1'b1,1'b0,4'h0,4'd1,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b1,32'h02020202, 1'b0,32'h12345678, 1'b1,32'h01010101, 1'b0,32'hDEADBEEF};
    vt[12] = '{1'b1,1'b0,4'h0,4'd2,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b1,32'hDEADBEEF, 1'b0,32'h12345678, 1'b1,32'h02020202, 1'b0,32'hDEADBEEF};
    vt[13] = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b0,32'hDEADBEEF, 1'b0,32'h12345678, 1'b1,32'hDEADBEEF, 1'b0,32'hDEADBEEF};
    vt[14] = '{1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0,1'b0,4'h0,4'd0,32'h0,        1'b0, 1'b0,32'hDEADBEEF, 1'b0,32'h12345678, 1'b0,32'hDEADBEEF, 1'b0,32'hDEADBEEF};

    set_idle();
    bcnt = 16;
    rst_n = 1;
    @(posedge clk);
    #1;
    do_reset();
    measure_busy("busy_len_first");

    // Clear sweep leaves addr 5 at zero.
    a_en = 1; a_we = 0; a_addr = 4'd5;
    cycle();
    $display("read addr5 after clear: rvalid=%0b rdata=%h", a_rvalid0, a_rdata0);
    chk("clr_rd5_valid", 32'(a_rvalid0), 32'h1);
    chk("clr_rd5_data", a_rdata0, 32'h0);
    set_idle();
    cycle();

    for (int i = 0; i < 15; i++) begin
      a_en = vt[i].a_en; a_we = vt[i].a_we; a_be = vt[i].a_be;
      a_addr = vt[i].a_addr; a_wdata = vt[i].a_wd;
      b_en = vt[i].b_en; b_we = vt[i].b_we; b_be = vt[i].b_be;
      b_addr = vt[i].b_addr; b_wdata = vt[i].b_wd;
      cycle();
      $display("vec %0d: a=%h/%0b b=%h/%0b a1=%h/%0b b1=%h/%0b col=%0b",
               i, a_rdata0, a_rvalid0, b_rdata0, b_rvalid0,
               a_rdata1, a_rvalid1, b_rdata1, b_rvalid1, col0);
      chk("vec_col0", 32'(col0), 32'(vt[i].col));
      chk("vec_col1", 32'(col1), 32'(vt[i].col));
      chk("vec_a_rv0", 32'(a_rvalid0), 32'(vt[i].a_rv0));
      chk("vec_a_rd0", a_rdata0, vt[i].a_rd0);
      chk("vec_b_rv0", 32'(b_rvalid0), 32'(vt[i].b_rv0));
      chk("vec_b_rd0", b_rdata0, vt[i].b_rd0);
      chk("vec_a_rv1", 32'(a_rvalid1), 32'(vt[i].a_rv1));
      chk("vec_a_rd1", a_rdata1, vt[i].a_rd1);
      chk("vec_b_rv1", 32'(b_rvalid1), 32'(vt[i].b_rv1));
      chk("vec_b_rd1", b_rdata1, vt[i].b_rd1);
    end

    // Random traffic over a narrow address window to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      a_en = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
      a_be = 4'($urandom); a_addr = 4'($urandom_range(0, 3)); a_wdata = $urandom;
      b_en = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
      b_be = 4'($urandom); b_addr = 4'($urandom_range(0, 3)); b_wdata = $urandom;
      cycle();
      $display("rnd %0d: a=%h/%0b b=%h/%0b col=%0b", i, a_rdata0, a_rvalid0,
               b_rdata0, b_rvalid0, col0);
    end

    // Reset in the middle of the sweep restarts it from the beginning.
    set_idle();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_en = 1; a_we = 1'($urandom_range(0, 1)); a_be = 4'hF;
      a_addr = 4'($urandom); a_wdata = $urandom;
      cycle();
    end
    do_reset();
    measure_busy("busy_len_restart");
    set_idle();
    for (int i = 0; i < 16; i++) begin
      a_en = 1; a_addr = 4'(i);
      cycle();
      chk("post_restart_zero", a_rdata0, 32'h0);
    end
    set_idle();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_sram_be.md
Name: dp_sram_be

Overview:
Parametrised true dual-port synchronous SRAM. It succeeds the tristate DUAL_SRAM and serves as the on-chip buffer for weight/activation storage in the binarynet datapath.
- Separate read/write data buses per port; no inout.
- Per-byte write enables and configurable read latency with a valid strobe.
- Defined same-address collision semantics.
- Optional hardware clear of the array after reset, signalled by busy.

Parameters:
DW, 32, data width in bits; must be a multiple of BW
AW, 6, address width; depth DP = 2**AW
BW, 8, write-lane width in bits; NL = DW/BW lanes
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)
WR_MODE, 0, same-address read/write behaviour: 0 = read-first (old data), 1 = write-first (new data)
CLR_ON_RST, 1, 1 = zero every word after reset release; 0 = no clear, contents undefined

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
a_en  in  1  port A request
a_we  in  1  port A write (1) / read (0), qualified by a_en
a_be  in  NL  port A lane write enables
a_addr  in  AW  port A address
a_wdata  in  DW  port A write data
a_rdata  out  DW  port A read data
a_rvalid  out  1  port A read data valid, one-cycle pulse
b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid: identical set for port B
busy  out  1  clear sweep in progress; requests ignored
collision  out  1  one-cycle pulse: both ports wrote an overlapping lane of the same address

Behaviour:
- Reset (rst_n low, asynchronous): a_rdata/b_rdata=0, a_rvalid/b_rvalid=0, collision=0, pipeline valids cleared.
  - busy=1 if CLR_ON_RST, else 0.
  - Memory array is not reset by rst_n itself.
- Clear FSM (CLR_ON_RST=1): states CLEAR and READY; reset enters CLEAR with counter=0.
  - CLEAR writes 0 to mem[counter] each cycle and increments the counter.
  - After writing DP-1, go to READY on the next edge; busy deasserts in the cycle READY is entered. busy is high for exactly DP cycles after reset release.
  - Reset asserted mid-sweep restarts the sweep at address 0.
  - With CLR_ON_RST=0 the FSM is absent and busy is tied 0.
- Request gating: an effective request is x_en & !busy. Requests while busy are dropped with no rvalid and no write.
- Read (x_en & !x_we) accepted at edge N:
  - x_rdata updates and x_rvalid=1 for one cycle after edge N+RD_LAT-1, i.e. visible in the cycle following edge N for RD_LAT=1.
  - x_rdata holds its last value when there is no read. Back-to-back reads are accepted every cycle.
- Write (x_en & x_we): for each lane i with x_be[i]=1, mem[addr][i*BW +: BW] <= x_wdata lane. A write with be=0 is a no-op. Writes never raise rvalid.
- Both ports write the same address in the same cycle:
  - Merge per lane: lanes in a_be take A's data.
  - Lanes in b_be & ~a_be take B's data.
  - collision pulses one cycle later iff (a_be & b_be) != 0.
  - Writes to different addresses proceed independently.
- One port reads and the other writes the same address in the same cycle:
  - WR_MODE=0: the read returns pre-write contents.
  - WR_MODE=1: the read returns the merged post-write word (written lanes new, others old).
- A port reading and writing itself is impossible; x_we selects one.
- Latency is unaffected by collisions. No back-pressure; the consumer must accept rvalid when it is presented.

Decomposition:
- Shared package binarynet_mem_pkg holds:
  - RD_FIRST/WR_FIRST mode constants;
  - the NL = DW/BW derivation;
  - clear-FSM state encoding.
- One sub-module, dp_sram_rdpipe: per-port read-data/valid pipeline of depth RD_LAT. It is instantiated twice.
- Array, write merge and clear FSM stay in the top level.

Test Plan:
- Reset clear (DW=32, AW=4, CLR_ON_RST=1): release rst_n -> busy high 16 cycles. A read of addr 5 issued while busy gives no rvalid. After busy falls, read addr 5 -> rdata=0x00000000 with rvalid after RD_LAT.
- Byte-lane write: A writes 0xAABBCCDD be=1111 to addr 3, then B writes 0x11223344 be=0101 to addr 3, then A reads addr 3 -> 0xAA22CC44.
- Dual-write collision: same cycle, A writes 0x000000FF be=0001 and B writes 0xFFFF00EE be=1101 to addr 7 -> mem[7]=0xFFFF00FF, collision=1 for one cycle. Repeat with B be=1100 -> collision stays 0.
- Read/write same address: mem[2]=0x12345678; A writes 0xDEADBEEF be=1111 while B reads addr 2 -> WR_MODE=0 gives b_rdata=0x12345678, WR_MODE=1 gives 0xDEADBEEF.
- Latency/throughput (RD_LAT=2): A reads addrs 0,1,2 on consecutive cycles -> a_rvalid high on three consecutive cycles starting 2 cycles after the first request, with data in order.
- Reset mid-sweep: assert rst_n low at sweep cycle 8 -> outputs zero immediately. After release, busy lasts a full 16 cycles again.
